// File: rtl/iter_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes immediately with an all-ones quotient and the dividend as the remainder.
module iter_divider #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             carry_out,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The stored partial remainder is always below the divisor, so its top bit is
    // implicitly 0; the WIDTH+1-bit trial operand is formed from it each cycle.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {prem_q, work_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            prem_q  <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            prem_q  <= prem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        prem_d  = prem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        work_d  = dividend;
                        dsr_d   = divisor;
                        prem_d  = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    prem_d = diff[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quo_d   = work_d;
                    rem_d   = prem_d;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign carry_out   = dbz_q;
    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);

endmodule
